// File: rtl/axil_s2mm_reg_slave_pkg.sv
// Purpose : shared constants for the S2MM register responder (offsets, bit indices, resp codes, FSM states).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package axil_s2mm_pkg;

  // Register byte offsets (word aligned)
  localparam logic [11:0] DMACR_OFF  = 12'h030;
  localparam logic [11:0] DMASR_OFF  = 12'h034;
  localparam logic [11:0] DA_OFF     = 12'h048;
  localparam logic [11:0] DA_MSB_OFF = 12'h04C;
  localparam logic [11:0] LENGTH_OFF = 12'h058;

  // DMACR bits
  localparam int RS_BIT        = 0;
  localparam int RESET_BIT     = 2;
  localparam int IOC_IRQEN_BIT = 12;

  // DMASR bits
  localparam int HALTED_BIT  = 0;
  localparam int IDLE_BIT    = 1;
  localparam int IOC_IRQ_BIT = 12;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axil_s2mm_reg_slave_if.sv
// Purpose : AXI4-Lite bus bundle between the write controller (master) and the S2MM register slave.
// Latency : n/a (wires only).
// Backpressure: standard AXI valid/ready on AW, W, B, AR, R.
// Ports   : aw*/w*/b* write channels, ar*/r* read channels; master and slave modports.
interface axil_s2mm_reg_slave_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_s2mm_reg_slave.sv
// Purpose : AXI4-Lite responder emulating the S2MM DMA register subset (DMACR/DMASR/DA/DA_MSB/LENGTH);
//           a legal LENGTH write launches one datapath transfer, completion raises IOC / s2mm_introut.
// Latency : bvalid 1 cycle after the later of AW/W; rvalid 1 cycle after AR; xfer_start 1 cycle after commit.
// Backpressure: AW/W/AR ready drop while a response is outstanding; B and R hold until bready/rready.
// Ports   : clk, rst (sync, active-high); s_axi_lite (slave modport); xfer_da/xfer_len/xfer_start to the
//           datapath, xfer_done from it; s2mm_introut level interrupt.
// Option  : S2MM_SOFT_RESET_EN enables the self-clearing DMACR.Reset bit.
module axil_s2mm_reg_slave
  import axil_s2mm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 26
) (
  input  logic                   clk,
  input  logic                   rst,
  axil_s2mm_reg_slave_if.slave   s_axi_lite,
  output logic [63:0]            xfer_da,
  output logic [LEN_W-1:0]       xfer_len,
  output logic                   xfer_start,
  input  logic                   xfer_done,
  output logic                   s2mm_introut
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  // Channel state
  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Register state
  logic              rs_q, rs_d, ioc_en_q, ioc_en_d, ioc_irq_q, ioc_irq_d, idle_q, idle_d;
  logic [31:0]       da_q, da_d, da_msb_q, da_msb_d;
  logic [LEN_W-1:0]  len_q, len_d, xfer_len_q, xfer_len_d;
  logic [63:0]       xfer_da_q, xfer_da_d;
  logic              xfer_start_q, xfer_start_d, introut_q, introut_d;

  logic              aw_hs, w_hs, commit;
  logic [ADDR_W-1:0] wr_word, rd_word;
  logic [31:0]       wr_data, rd_val;
  logic              rd_err;
`ifdef S2MM_SOFT_RESET_EN
  logic              soft_rst;
`endif

  assign aw_hs   = s_axi_lite.awvalid & awready_q;
  assign w_hs    = s_axi_lite.wvalid & wready_q;
  // The beat arriving this cycle is used directly so the commit happens in the same cycle.
  assign wr_word = (aw_got_q ? awaddr_q : s_axi_lite.awaddr) & WORD_MASK;
  assign wr_data = w_got_q ? wdata_q : s_axi_lite.wdata;
  assign commit  = (w_state_q == W_IDLE) & (aw_got_q | aw_hs) & (w_got_q | w_hs);
  assign rd_word = s_axi_lite.araddr & WORD_MASK;

  // Read mux works on current register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    case (rd_word)
      ADDR_W'(DMACR_OFF): begin
        rd_val[RS_BIT]        = rs_q;
        rd_val[IOC_IRQEN_BIT] = ioc_en_q;
      end
      ADDR_W'(DMASR_OFF): begin
        rd_val[HALTED_BIT]  = ~rs_q;
        rd_val[IDLE_BIT]    = idle_q;
        rd_val[IOC_IRQ_BIT] = ioc_irq_q;
      end
      ADDR_W'(DA_OFF):     rd_val = da_q;
      ADDR_W'(DA_MSB_OFF): rd_val = da_msb_q;
      ADDR_W'(LENGTH_OFF): rd_val[LEN_W-1:0] = len_q;
      default:             rd_err = 1'b1;
    endcase
  end

  always_comb begin
    w_state_d    = w_state_q;
    r_state_d    = r_state_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    aw_got_d     = aw_got_q;
    w_got_d      = w_got_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    arready_d    = arready_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rs_d         = rs_q;
    ioc_en_d     = ioc_en_q;
    ioc_irq_d    = ioc_irq_q;
    idle_d       = idle_q;
    da_d         = da_q;
    da_msb_d     = da_msb_q;
    len_d        = len_q;
    xfer_da_d    = xfer_da_q;
    xfer_len_d   = xfer_len_q;
    xfer_start_d = 1'b0;
    introut_d    = ioc_irq_q & ioc_en_q;
`ifdef S2MM_SOFT_RESET_EN
    soft_rst     = 1'b0;
`endif

    // Write channel: AW and W captured independently, commit once both are held.
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi_lite.awaddr;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_lite.wdata;
        end
        if (commit) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = RESP_OKAY;
          w_state_d = W_RESP;
          case (wr_word)
            ADDR_W'(DMACR_OFF): begin
              rs_d     = wr_data[RS_BIT];
              ioc_en_d = wr_data[IOC_IRQEN_BIT];
`ifdef S2MM_SOFT_RESET_EN
              soft_rst = wr_data[RESET_BIT];
`endif
            end
            ADDR_W'(DMASR_OFF): if (wr_data[IOC_IRQ_BIT]) ioc_irq_d = 1'b0;
            ADDR_W'(DA_OFF):     da_d = wr_data;
            ADDR_W'(DA_MSB_OFF): da_msb_d = wr_data;
            ADDR_W'(LENGTH_OFF): begin
              if (rs_q && idle_q) begin
                len_d = wr_data[LEN_W-1:0];
                // Zero length is stored but never launched.
                if (|wr_data[LEN_W-1:0]) begin
                  xfer_da_d    = {da_msb_q, da_q};
                  xfer_len_d   = wr_data[LEN_W-1:0];
                  idle_d       = 1'b0;
                  xfer_start_d = 1'b1;
                end
              end else begin
                bresp_d = RESP_SLVERR;
              end
            end
            default: bresp_d = RESP_SLVERR;
          endcase
        end else begin
          awready_d = ~aw_got_d;
          wready_d  = ~w_got_d;
        end
      end
      W_RESP: begin
        if (s_axi_lite.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
    endcase

    // Completion set is applied after the W1C so a coincident set wins.
    if (xfer_done && !idle_q) begin
      idle_d    = 1'b1;
      ioc_irq_d = 1'b1;
    end

`ifdef S2MM_SOFT_RESET_EN
    // Abandons any busy transfer; the B response in flight is unaffected.
    if (soft_rst) begin
      rs_d         = 1'b0;
      ioc_en_d     = 1'b0;
      ioc_irq_d    = 1'b0;
      idle_d       = 1'b1;
      da_d         = '0;
      da_msb_d     = '0;
      len_d        = '0;
      xfer_da_d    = '0;
      xfer_len_d   = '0;
      xfer_start_d = 1'b0;
      introut_d    = 1'b0;
    end
`endif

    // Read channel
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_lite.arvalid && arready_q) begin
          rdata_d   = rd_val;
          rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_lite.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_got_q     <= 1'b0;
      w_got_q      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rs_q         <= 1'b0;
      ioc_en_q     <= 1'b0;
      ioc_irq_q    <= 1'b0;
      idle_q       <= 1'b1;
      da_q         <= '0;
      da_msb_q     <= '0;
      len_q        <= '0;
      xfer_da_q    <= '0;
      xfer_len_q   <= '0;
      xfer_start_q <= 1'b0;
      introut_q    <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      aw_got_q     <= aw_got_d;
      w_got_q      <= w_got_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rs_q         <= rs_d;
      ioc_en_q     <= ioc_en_d;
      ioc_irq_q    <= ioc_irq_d;
      idle_q       <= idle_d;
      da_q         <= da_d;
      da_msb_q     <= da_msb_d;
      len_q        <= len_d;
      xfer_da_q    <= xfer_da_d;
      xfer_len_q   <= xfer_len_d;
      xfer_start_q <= xfer_start_d;
      introut_q    <= introut_d;
    end
  end

  assign s_axi_lite.awready = awready_q;
  assign s_axi_lite.wready  = wready_q;
  assign s_axi_lite.bvalid  = bvalid_q;
  assign s_axi_lite.bresp   = bresp_q;
  assign s_axi_lite.arready = arready_q;
  assign s_axi_lite.rvalid  = rvalid_q;
  assign s_axi_lite.rdata   = rdata_q;
  assign s_axi_lite.rresp   = rresp_q;
  assign xfer_da            = xfer_da_q;
  assign xfer_len           = xfer_len_q;
  assign xfer_start         = xfer_start_q;
  assign s2mm_introut       = introut_q;

endmodule
